byte_frame_checker: RTL and testbench

BYTE_FRAME_CHECKER -- requirements
Module: byte_frame_checker

---
 rtl/byte_frame_checker.sv | 163 ++++++++++++++++
 tb/tb_byte_frame_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_frame_checker.sv
// Byte-stream frame checker.
// Frame format: SYNC_BYTE, length L, L payload bytes, then a checksum byte.
// The checksum byte must equal the 8-bit sum of L and all payload bytes.
// Bad length, bad checksum and mid-frame idle timeouts each abort the frame
// and report a cause code. Good and bad frames are counted with saturation.
module byte_frame_checker #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 64,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [7:0]       data_in,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  // Idle counter is wide enough for the largest supported TIMEOUT (1023).
  localparam int                IDLE_W       = 10;
  localparam logic [7:0]        MAX_LEN_B    = 8'(MAX_LEN);
  localparam logic [IDLE_W-1:0] TIMEOUT_C    = IDLE_W'(TIMEOUT);
  localparam logic [1:0]        CODE_LEN     = 2'b01;
  localparam logic [1:0]        CODE_CSUM    = 2'b10;
  localparam logic [1:0]        CODE_TIMEOUT = 2'b11;

  state_t            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  ok_count_q, ok_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [IDLE_W-1:0] idle_inc;

  assign idle_inc = idle_q + 1'b1;

  // Frame parser: next state, running sum, remaining count, idle timer and result pulses.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    remaining_d = remaining_q;
    idle_d      = idle_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    if (state_q == HUNT) begin
      idle_d = '0;
      if (valid && (data_in == SYNC_BYTE)) begin
        state_d = LEN;
        sum_d   = 8'd0;
      end
    end else if (!valid) begin
      idle_d = idle_inc;
      if (idle_inc == TIMEOUT_C) begin
        frame_err_d = 1'b1;
        err_code_d  = CODE_TIMEOUT;
        state_d     = HUNT;
        idle_d      = '0;
      end
    end else begin
      idle_d = '0;
      case (state_q)
        LEN: begin
          remaining_d = data_in;
          sum_d       = data_in;
          if (data_in > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = CODE_LEN;
            state_d     = HUNT;
          end else if (data_in == 8'd0) begin
            state_d = CSUM;
          end else begin
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          sum_d       = sum_q + data_in;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = CSUM;
          end
        end
        CSUM: begin
          if (data_in == sum_q) begin
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = CODE_CSUM;
          end
          state_d = HUNT;
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Status decode and saturating frame counters, updated alongside the pulses.
  always_comb begin
    busy_d      = (state_d != HUNT);
    ok_count_d  = ok_count_q;
    err_count_d = err_count_q;
    if (frame_ok_d && (ok_count_q != {CNT_W{1'b1}})) begin
      ok_count_d = ok_count_q + 1'b1;
    end
    if (frame_err_d && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      sum_q       <= 8'd0;
      remaining_q <= 8'd0;
      idle_q      <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      busy_q      <= 1'b0;
      ok_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      remaining_q <= remaining_d;
      idle_q      <= idle_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
      ok_count_q  <= ok_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;
  assign ok_count  = ok_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_byte_frame_checker.sv
// Directed testbench for byte_frame_checker.
// Counters are built 2 bits wide here so that saturation at 3 is reachable.
module tb_byte_frame_checker;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [7:0] data_in;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
  logic [1:0] ok_count;
  logic [1:0] err_count;

  int checks;
  int failures;

  byte_frame_checker #(
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (16),
    .TIMEOUT   (64),
    .CNT_W     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .data_in   (data_in),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy),
    .ok_count  (ok_count),
    .err_count (err_count)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of input on the falling edge, then settle just past the rising edge.
  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    valid   = v;
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 8'h00);
    step(1'b1, 8'hA5);
    rst_n = 1'b1;
    checks++; if (frame_ok !== 1'b0) begin failures++; $display("[TB] FAIL reset_ok: got %b want 0", frame_ok); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b want 0", frame_err); end
    checks++; if (err_code !== 2'b00) begin failures++; $display("[TB] FAIL reset_code: got %b want 00", err_code); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ok_count !== 2'd0) begin failures++; $display("[TB] FAIL reset_okcnt: got %0d want 0", ok_count); end
    checks++; if (err_count !== 2'd0) begin failures++; $display("[TB] FAIL reset_errcnt: got %0d want 0", err_count); end
  endtask

  // A5 03 10 20 30 63: sum 03+10+20+30 = 63.
  task automatic test_good_frame();
    step(1'b1, 8'hA5);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL good_busy: got %b want 1", busy); end
    step(1'b1, 8'h03);
    step(1'b1, 8'h10);
    step(1'b1, 8'h20);
    step(1'b1, 8'h30);
    checks++; if (frame_ok !== 1'b0) begin failures++; $display("[TB] FAIL good_early: got %b want 0", frame_ok); end
    step(1'b1, 8'h63);
    checks++; if (frame_ok !== 1'b1) begin failures++; $display("[TB] FAIL good_ok: got %b want 1", frame_ok); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL good_noerr: got %b want 0", frame_err); end
    checks++; if (ok_count !== 2'd1) begin failures++; $display("[TB] FAIL good_okcnt: got %0d want 1", ok_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL good_idle: got %b want 0", busy); end
    step(1'b0, 8'h00);
    checks++; if (frame_ok !== 1'b0) begin failures++; $display("[TB] FAIL good_pulse: got %b want 0", frame_ok); end
  endtask

  // Same frame with the checksum off by one.
  task automatic test_checksum_err();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h03);
    step(1'b1, 8'h10);
    step(1'b1, 8'h20);
    step(1'b1, 8'h30);
    step(1'b1, 8'h64);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("[TB] FAIL csum_err: got %b want 1", frame_err); end
    checks++; if (frame_ok !== 1'b0) begin failures++; $display("[TB] FAIL csum_nook: got %b want 0", frame_ok); end
    checks++; if (err_code !== 2'b10) begin failures++; $display("[TB] FAIL csum_code: got %b want 10", err_code); end
    checks++; if (err_count !== 2'd1) begin failures++; $display("[TB] FAIL csum_errcnt: got %0d want 1", err_count); end
    step(1'b0, 8'h00);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL csum_pulse: got %b want 0", frame_err); end
    checks++; if (err_code !== 2'b10) begin failures++; $display("[TB] FAIL csum_hold: got %b want 10", err_code); end
  endtask

  // Length 0x11 exceeds MAX_LEN; then a stray 00 is ignored and a zero-length frame passes.
  task automatic test_length_err();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h10);
    step(1'b1, 8'hA5);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL len_max_legal: got busy %b want 1", busy); end
    rst_n = 1'b0;
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h03);
    step(1'b1, 8'h10);
    step(1'b1, 8'h20);
    step(1'b1, 8'h30);
    step(1'b1, 8'h64);
    step(1'b1, 8'hA5);
    step(1'b1, 8'h11);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("[TB] FAIL len_err: got %b want 1", frame_err); end
    checks++; if (err_code !== 2'b01) begin failures++; $display("[TB] FAIL len_code: got %b want 01", err_code); end
    checks++; if (err_count !== 2'd2) begin failures++; $display("[TB] FAIL len_errcnt: got %0d want 2", err_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL len_busy: got %b want 0", busy); end
    step(1'b1, 8'h00);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL len_ignore: got busy %b want 0", busy); end
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    checks++; if (frame_ok !== 1'b1) begin failures++; $display("[TB] FAIL zero_ok: got %b want 1", frame_ok); end
    checks++; if (ok_count !== 2'd1) begin failures++; $display("[TB] FAIL zero_okcnt: got %0d want 1", ok_count); end
    checks++; if (err_code !== 2'b01) begin failures++; $display("[TB] FAIL zero_codehold: got %b want 01", err_code); end
  endtask

  // 64 idle cycles mid-frame abort; 63 idle cycles do not.
  task automatic test_timeout();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h02);
    for (int i = 0; i < 63; i++) step(1'b0, 8'h00);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL to_early: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL to_busy: got %b want 1", busy); end
    step(1'b0, 8'h00);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("[TB] FAIL to_err: got %b want 1", frame_err); end
    checks++; if (err_code !== 2'b11) begin failures++; $display("[TB] FAIL to_code: got %b want 11", err_code); end
    checks++; if (err_count !== 2'd3) begin failures++; $display("[TB] FAIL to_errcnt: got %0d want 3", err_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL to_idle: got %b want 0", busy); end
    // Sum is 02+01+02 = 05.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h02);
    for (int i = 0; i < 63; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h05);
    checks++; if (frame_ok !== 1'b1) begin failures++; $display("[TB] FAIL gap63_ok: got %b want 1", frame_ok); end
    checks++; if (ok_count !== 2'd2) begin failures++; $display("[TB] FAIL gap63_okcnt: got %0d want 2", ok_count); end
  endtask

  // Junk ignored in HUNT; a sync value inside the payload is plain data (sum 01+A5 = A6).
  task automatic test_sync_in_payload();
    step(1'b1, 8'h5A);
    step(1'b1, 8'hFF);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL junk_busy: got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL junk_err: got %b want 0", frame_err); end
    step(1'b1, 8'hA5);
    step(1'b1, 8'h01);
    step(1'b1, 8'hA5);
    step(1'b1, 8'hA6);
    checks++; if (frame_ok !== 1'b1) begin failures++; $display("[TB] FAIL syncdata_ok: got %b want 1", frame_ok); end
    checks++; if (ok_count !== 2'd3) begin failures++; $display("[TB] FAIL syncdata_okcnt: got %0d want 3", ok_count); end
  endtask

  // Frames with no gap; counters are now saturated at 3.
  task automatic test_back_to_back();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    checks++; if (frame_ok !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ok: got %b want 1", frame_ok); end
    checks++; if (ok_count !== 2'd3) begin failures++; $display("[TB] FAIL b2b_oksat: got %0d want 3", ok_count); end
    step(1'b1, 8'hA5);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart: got %b want 1", busy); end
    checks++; if (frame_ok !== 1'b0) begin failures++; $display("[TB] FAIL b2b_pulse: got %b want 0", frame_ok); end
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("[TB] FAIL b2b_err: got %b want 1", frame_err); end
    checks++; if (err_code !== 2'b10) begin failures++; $display("[TB] FAIL b2b_code: got %b want 10", err_code); end
    checks++; if (err_count !== 2'd3) begin failures++; $display("[TB] FAIL b2b_errsat: got %0d want 3", err_count); end
  endtask

  // Reset during a frame clears everything without a pulse; the next frame is parsed from HUNT.
  task automatic test_reset_mid_frame();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h04);
    step(1'b1, 8'h01);
    rst_n = 1'b0;
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    checks++; if (frame_ok !== 1'b0) begin failures++; $display("[TB] FAIL rmid_ok: got %b want 0", frame_ok); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL rmid_err: got %b want 0", frame_err); end
    checks++; if (err_code !== 2'b00) begin failures++; $display("[TB] FAIL rmid_code: got %b want 00", err_code); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (ok_count !== 2'd0) begin failures++; $display("[TB] FAIL rmid_okcnt: got %0d want 0", ok_count); end
    checks++; if (err_count !== 2'd0) begin failures++; $display("[TB] FAIL rmid_errcnt: got %0d want 0", err_count); end
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    checks++; if (frame_ok !== 1'b1) begin failures++; $display("[TB] FAIL rmid_newok: got %b want 1", frame_ok); end
    checks++; if (ok_count !== 2'd1) begin failures++; $display("[TB] FAIL rmid_newcnt: got %0d want 1", ok_count); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL rmid_newerr: got %b want 0", frame_err); end
  endtask

  // Test sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    valid    = 1'b0;
    data_in  = 8'h00;
    $display("[TB] byte_frame_checker directed test start");
    test_reset();
    test_good_frame();
    test_checksum_err();
    test_length_err();
    test_timeout();
    test_sync_in_payload();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
